// File: rtl/motor_mux_pkg.sv
// Shared types and default timing constants for the motor output mux
// reconfiguration controller.
package motor_mux_pkg;

  localparam int SEL_W = 3;

  localparam int DEF_GUARD_CYCLES = 16;
  localparam int DEF_SETUP_CYCLES = 50;
  localparam int DEF_QUIESCE_MAX  = 1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_GAP,
    ST_SETUP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/motor_mux_ctrl_if.sv
// Host-side request handshake for one motor mux controller.
interface motor_mux_ctrl_if;
  import motor_mux_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [SEL_W-1:0] cfg_select;
  logic             cfg_invert;
  logic             cfg_enable;
  logic             done;

  modport master (
    output cfg_valid, cfg_select, cfg_invert, cfg_enable,
    input  cfg_ready, done
  );

  modport slave (
    input  cfg_valid, cfg_select, cfg_invert, cfg_enable,
    output cfg_ready, done
  );
endinterface

// File: rtl/motor_mux_ctrl.sv
// Sequences a source/polarity change on one motor output mux: wait for the
// step pulse to end, blank, switch, wait dir-setup, then re-enable.
module motor_mux_ctrl
  import motor_mux_pkg::*;
#(
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int QUIESCE_MAX  = DEF_QUIESCE_MAX
) (
  input  logic             clk,
  input  logic             reset,
  motor_mux_ctrl_if.slave  cfg,
  input  logic             step_mon,
  output logic [SEL_W-1:0] mux_select,
  output logic             invert_dir,
  output logic             enable,
  output logic             quiesce_timeout
);

  localparam int CNT_W = $clog2(max3(GUARD_CYCLES, SETUP_CYCLES, QUIESCE_MAX) + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  // Counter holds "cycles remaining after this one", so zero marks the last cycle.
  localparam cnt_t GUARD_LD   = cnt_t'(GUARD_CYCLES - 1);
  localparam cnt_t SETUP_LD   = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t QUIESCE_LD = cnt_t'(QUIESCE_MAX - 1);

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [SEL_W-1:0] mux_select_q, mux_select_d;
  logic             invert_dir_q, invert_dir_d;
  logic             enable_q, enable_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [SEL_W-1:0] req_select_q, req_select_d;
  logic             req_invert_q, req_invert_d;
  logic             req_enable_q, req_enable_d;

  logic same_route;
  logic release_ok;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mux_select_d = mux_select_q;
    invert_dir_d = invert_dir_q;
    enable_d     = enable_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    req_select_d = req_select_q;
    req_invert_d = req_invert_q;
    req_enable_d = req_enable_q;

    same_route = (req_select_q == mux_select_q) && (req_invert_q == invert_dir_q);
    // Keeping an already-enabled output enabled on the same route needs no
    // quiet step, so that case never waits.
    release_ok = !enable_q || !step_mon || (same_route && req_enable_q);

    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          req_select_d = cfg.cfg_select;
          req_invert_d = cfg.cfg_invert;
          req_enable_d = cfg.cfg_enable;
          cnt_d        = QUIESCE_LD;
          state_d      = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (release_ok || (cnt_q == '0)) begin
          if (!release_ok) timeout_d = 1'b1;
          if (!same_route) begin
            enable_d = 1'b0;
            cnt_d    = GUARD_LD;
            state_d  = ST_GAP;
          end else begin
            enable_d = req_enable_q;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          mux_select_d = req_select_q;
          invert_dir_d = req_invert_q;
          cnt_d        = SETUP_LD;
          state_d      = ST_SETUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          enable_d = req_enable_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      mux_select_q <= '0;
      invert_dir_q <= 1'b0;
      enable_q     <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mux_select_q <= mux_select_d;
      invert_dir_q <= invert_dir_d;
      enable_q     <= enable_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
    // The request latch is only read outside IDLE, so it needs no reset.
    req_select_q <= req_select_d;
    req_invert_q <= req_invert_d;
    req_enable_q <= req_enable_d;
  end

  assign cfg.cfg_ready    = ready_q;
  assign cfg.done         = done_q;
  assign mux_select       = mux_select_q;
  assign invert_dir       = invert_dir_q;
  assign enable           = enable_q;
  assign quiesce_timeout  = timeout_q;

endmodule
